// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants for the inter-stage pipeline buffers: reset polarity,
// the pc/inst bus width and the per-stage payload bus widths.
package pipe_stage_buf_pkg;

    localparam logic RST_ENABLE      = 1'b0;
    localparam int   PC_INST_BUS_LEN = 64;

    localparam int   IF_TO_ID_BUS_LEN  = 32;
    localparam int   ID_TO_EX_BUS_LEN  = 150;
    localparam int   EX_TO_MEM_BUS_LEN = 76;
    localparam int   MEM_TO_WB_BUS_LEN = 70;

    function automatic logic [1:0] entry_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// One buffer entry: a valid flag plus its data word, with load and clear enables.
// Clear wins over load; data only changes on load.
module pipe_skid_entry
    import pipe_stage_buf_pkg::*;
#(
    parameter int W = 96
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/allowin handshake and synchronous flush.
// SKID=0: one entry, combinational allowin. SKID=1: two entries, allowin from a flop.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = PC_INST_BUS_LEN,
    parameter bit SKID   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              allowin_o,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        cnt_o
);

    localparam int W = PC_W + DATA_W;

    logic [W-1:0] in_word;
    logic [W-1:0] main_d;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         main_valid;
    logic         skid_valid;
    logic         in_fire;
    logic         out_fire;
    logic         main_load;
    logic         main_clear;
    logic         skid_load;
    logic         skid_clear;
    logic         main_nxt;
    logic         skid_nxt;

    assign in_word  = {pc_i, data_i};
    assign in_fire  = valid_i & allowin_o;
    assign out_fire = main_valid & ready_i;

    // A held skid word always drains into main before any new input is taken.
    assign main_d     = skid_valid ? skid_q : in_word;
    assign main_load  = ~flush_i & ((in_fire & (~main_valid | out_fire))
                                  | (out_fire & skid_valid));
    assign main_clear = flush_i | (out_fire & ~in_fire & ~skid_valid);

    pipe_skid_entry #(.W(W)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    generate
        if (SKID) begin : g_skid
            assign skid_load  = ~flush_i & in_fire & main_valid & ~out_fire;
            assign skid_clear = flush_i | (out_fire & skid_valid);
            // skid_valid is a flop, so allowin has no path from ready_i/valid_i.
            assign allowin_o  = ~skid_valid;

            pipe_skid_entry #(.W(W)) u_skid (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (skid_load),
                .clear (skid_clear),
                .d     (in_word),
                .valid (skid_valid),
                .q     (skid_q)
            );
        end else begin : g_pass
            assign skid_load  = 1'b0;
            assign skid_clear = 1'b0;
            assign skid_valid = 1'b0;
            assign skid_q     = '0;
            assign allowin_o  = ~main_valid | ready_i;
        end
    endgenerate

    assign main_nxt = main_clear ? 1'b0 : (main_load ? 1'b1 : main_valid);
    assign skid_nxt = skid_clear ? 1'b0 : (skid_load ? 1'b1 : skid_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            cnt_o <= 2'd0;
        end else begin
            cnt_o <= entry_count(main_nxt, skid_nxt);
        end
    end

    assign valid_o        = main_valid;
    assign {pc_o, data_o} = main_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives SKID=0 and SKID=1 instances with shared stimulus; a reference FIFO per
// instance collects expected words and a negedge monitor compares outputs.
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic        ready = 1'b0;
    logic [63:0] pc = '0;
    logic [31:0] data = '0;

    logic        allow0, vld0, allow1, vld1;
    logic [63:0] pc0, pc1;
    logic [31:0] dat0, dat1;
    logic [1:0]  cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    typedef logic [95:0] ent_t;
    ent_t q0[$];
    ent_t q1[$];
    bit   in0, in1;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(32), .PC_W(64), .SKID(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .valid_i(valid), .allowin_o(allow0),
        .pc_i(pc), .data_i(data), .valid_o(vld0), .ready_i(ready), .pc_o(pc0),
        .data_o(dat0), .cnt_o(cnt0)
    );

    pipe_stage_buf #(.DATA_W(32), .PC_W(64), .SKID(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .valid_i(valid), .allowin_o(allow1),
        .pc_i(pc), .data_i(data), .valid_o(vld1), .ready_i(ready), .pc_o(pc1),
        .data_o(dat1), .cnt_o(cnt1)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_allow(input bit skid, input int n, input logic rdy);
        return skid ? (n < 2) : (n == 0 || rdy == 1'b1);
    endfunction

    // Reference FIFOs: flush empties them, otherwise pop on output and push on input.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else if (flush) begin
            q0.delete();
            q1.delete();
        end else begin
            in0 = valid && m_allow(1'b0, q0.size(), ready);
            in1 = valid && m_allow(1'b1, q1.size(), ready);
            if (q0.size() > 0 && ready) void'(q0.pop_front());
            if (q1.size() > 0 && ready) void'(q1.pop_front());
            if (in0) q0.push_back({pc, data});
            if (in1) q1.push_back({pc, data});
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("valid0", vld0, q0.size() > 0);
            check("cnt0", cnt0, q0.size());
            check("allow0", allow0, m_allow(1'b0, q0.size(), ready));
            if (vld0 && q0.size() > 0) check("word0", {pc0, dat0}, q0[0]);
            check("valid1", vld1, q1.size() > 0);
            check("cnt1", cnt1, q1.size());
            check("allow1", allow1, m_allow(1'b1, q1.size(), ready));
            if (vld1 && q1.size() > 0) check("word1", {pc1, dat1}, q1[0]);
        end
    end

    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
        @(posedge clk);
        #1;
        valid = v;
        pc    = 64'h1000 + {32'd0, d};
        data  = d;
        ready = r;
        flush = f;
    endtask

    initial begin
        // Reset with a word already presented upstream.
        valid = 1'b1;
        pc    = 64'h1C000000;
        ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid0", vld0, 1'b0);
        check("rst_pc0", pc0, 64'd0);
        check("rst_cnt0", cnt0, 2'd0);
        check("rst_allow0", allow0, 1'b1);
        check("rst_valid1", vld1, 1'b0);
        check("rst_data1", dat1, 32'd0);
        check("rst_cnt1", cnt1, 2'd0);
        check("rst_allow1", allow1, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_pc0", pc0, 64'h1C000000);
        check("first_pc1", pc1, 64'h1C000000);
        check("first_valid1", vld1, 1'b1);

        // Streaming at full rate.
        step(1'b0, 32'd0, 1'b1, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            step(k <= 4, k, 1'b1, 1'b0);
            if (k > 1) begin
                check("stream_data0", dat0, k - 1);
                check("stream_valid0", vld0, 1'b1);
                check("stream_allow0", allow0, 1'b1);
            end
        end

        // Stall fills the skid entry; data_o holds the first word.
        step(1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        check("stall_cnt1_first", cnt1, 2'd1);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        check("stall_cnt1_full", cnt1, 2'd2);
        check("stall_allow1", allow1, 1'b0);
        check("stall_data1", dat1, 32'hA);
        ready = 1'b1;
        #1;
        check("no_comb_allow1", allow1, 1'b0);
        check("comb_allow0", allow0, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("drain_data1", dat1, 32'hB);
        check("drain_cnt1", cnt1, 2'd1);
        check("drain_allow1", allow1, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("drain_empty1", vld1, 1'b0);

        // Flush with a simultaneous input: the input is dropped.
        step(1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b1);
        check("pre_flush_cnt1", cnt1, 2'd2);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        check("flush_valid1", vld1, 1'b0);
        check("flush_cnt1", cnt1, 2'd0);
        check("flush_allow1", allow1, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("flush_no_c1", vld1, 1'b0);

        // Simultaneous input and output keeps the skid entry unused.
        step(1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b1, 32'h5, 1'b0, 1'b0);
        step(1'b1, 32'h6, 1'b1, 1'b0);
        check("simul_data1_a", dat1, 32'h5);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("simul_data1_b", dat1, 32'h6);
        check("simul_cnt1", cnt1, 2'd1);

        // Reset in the middle of a stall.
        step(1'b1, 32'h7, 1'b0, 1'b0);
        step(1'b1, 32'h8, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid1", vld1, 1'b0);
        check("midrst_cnt1", cnt1, 2'd0);
        check("midrst_allow1", allow1, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0);
        end
        step(1'b0, 32'd0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed-width inter-stage pipeline register; carries a {pc, inst} word plus a stage payload bus between any two pipeline stages (IF/ID, ID/EX, EX/MEM, ...).
- Uses the valid/allowin handshake. Adds a synchronous flush for branch redirect and exceptions.
- Adds an optional 2-entry skid mode. In skid mode the upstream allowin comes from a register, which breaks the combinational ready chain through the pipeline.

Parameters:
- DATA_W, 32: payload (stage bus) width in bits, ≥ 1.
- PC_W, 64: pc+inst bus width in bits, ≥ 1.
- SKID, 0: 0 = single-entry pass register with combinational allowin; 1 = two-entry skid buffer with registered allowin.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous kill of all held entries.
- valid_i  in  1  upstream has a valid word this cycle.
- allowin_o  out  1  this block accepts a word this cycle.
- pc_i  in  PC_W  upstream pc/inst bus.
- data_i  in  DATA_W  upstream payload.
- valid_o  out  1  head entry is valid.
- ready_i  in  1  downstream allowin.
- pc_o  out  PC_W  head pc/inst, registered.
- data_o  out  DATA_W  head payload, registered.
- cnt_o  out  2  number of valid entries held (0..1 for SKID=0, 0..2 for SKID=1).

Behaviour:
- Reset (rst_n low, asynchronous): valid_o=0, pc_o=0, data_o=0, skid entry valid=0 and skid data=0, cnt_o=0.
  - allowin_o=1 while in reset for SKID=1; for SKID=0 it follows its equation, which also gives 1.
- Transfers:
  - Input transfer: in_fire = valid_i & allowin_o.
  - Output transfer: out_fire = valid_o & ready_i.
- SKID=0:
  - allowin_o = !valid_o | ready_i, combinational.
  - On in_fire: pc_o/data_o ← inputs and valid_o ← 1.
  - Else if out_fire: valid_o ← 0 and the data is held.
  - Otherwise everything holds.
  - Latency is 1 cycle.
- SKID=1: allowin_o = !skid_valid, driven from a flop. There is no combinational path from ready_i or valid_i to allowin_o. Per-cycle cases:
  - in_fire, main empty: main ← in.
  - in_fire, main full, out_fire: main ← in.
  - in_fire, main full, no out_fire: skid ← in and skid_valid ← 1. allowin_o drops on the next cycle.
  - out_fire, skid valid: main ← skid and skid_valid ← 0. An in_fire cannot occur in this case because allowin_o=0.
  - out_fire, no in_fire, skid empty: valid_o ← 0.
  - Ordering is preserved in all cases; the skid entry is never bypassed.
- Flush:
  - flush_i=1 at a clock edge clears valid_o and skid_valid to 0, clears cnt_o to 0, and sets allowin_o to 1 on the next cycle.
  - An in_fire in the same cycle is dropped: flush has priority over input.
  - Data registers may hold stale values while their valid is 0.
- Data registers load only on an accepted transfer. They never change while valid_o=1 and ready_i=0 (stall stability).
- cnt_o = valid_o + skid_valid, registered. cnt_o=2 exactly when allowin_o=0 in SKID=1.
- Reset asserted mid-transfer discards all entries immediately. After release, the first edge behaves as from empty.
- Invariant: skid_valid=1 implies valid_o=1.
- Illegal cases:
  - valid_i changing while allowin_o=0 is legal; the block simply ignores the input.
  - There is no overflow path: the bench must check that no write occurs when cnt_o=2.

Decomposition:
- Shared package/header: PcInstBusLen default value, RstEnable polarity constant (1'b0), and the per-stage bus width macros (IdToExBusLen etc.) used to set DATA_W at instantiation.
- One natural sub-module: pipe_skid_entry. It is a single valid+data flop pair with load/clear enables, instantiated twice for SKID=1 and once for SKID=0 via a generate block.

Test Plan:
- Reset: hold rst_n=0 with valid_i=1 and pc_i=64'h1C000000 → valid_o=0, pc_o=0, cnt_o=0, allowin_o=1. Deassert rst_n → the word appears on pc_o one cycle after the first accepting edge.
- Streaming: SKID=0, ready_i=1, valid_i=1 every cycle, data_i=1,2,3,4 → data_o=1,2,3,4 on consecutive cycles at latency 1, valid_o stays 1, allowin_o stays 1.
- Stall: SKID=1, ready_i=0, valid_i=1 with data 0xA then 0xB → cnt_o goes 1 then 2, allowin_o=0 from the third cycle, data_o holds 0xA. Set ready_i=1 → data_o=0xA then 0xB in order, and allowin_o returns to 1 one cycle after the first out_fire.
- Flush priority: SKID=1 with cnt_o=2; assert flush_i together with valid_i=1 and data_i=0xC → next cycle valid_o=0, cnt_o=0, allowin_o=1. 0xC is never emitted.
- Simultaneous in/out: SKID=1, main holds 0x5, ready_i=1, valid_i=1 with data 0x6 → next cycle data_o=0x6, cnt_o=1, skid is never used.
- Random: random valid_i/ready_i/flush_i against a scoreboard reference FIFO (depth 1 or 2), ≥ 10k cycles per SKID value → no drops or duplicates except words killed by flush, and no combinational ready_i→allowin_o path in SKID=1 (checked structurally).
